// File: rtl/mc_control_pkg.sv
// Shared types and constants for the multi-cycle MIPS-subset controller:
// state encodings, opcode/funct values, ALU codes and datapath mux selects.
package mc_control_pkg;

  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned FUNCT_W  = 6;
  localparam int unsigned ALU_W    = 3;
  localparam int unsigned STATE_W  = 4;

  typedef logic [OPCODE_W-1:0] opcode_t;
  typedef logic [FUNCT_W-1:0]  funct_t;
  typedef logic [ALU_W-1:0]    alu_op_t;

  typedef enum logic [STATE_W-1:0] {
    IDLE      = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    MEM_ADR   = 4'd3,
    MEM_RD    = 4'd4,
    MEM_WB    = 4'd5,
    MEM_WR    = 4'd6,
    R_EXEC    = 4'd7,
    R_WB      = 4'd8,
    ADDI_EXEC = 4'd9,
    ADDI_WB   = 4'd10,
    BRANCH    = 4'd11,
    JUMP      = 4'd12
  } state_e;

  localparam opcode_t OP_RTYPE = 6'b000000;
  localparam opcode_t OP_LW    = 6'b100011;
  localparam opcode_t OP_SW    = 6'b101011;
  localparam opcode_t OP_ADDI  = 6'b001000;
  localparam opcode_t OP_BEQ   = 6'b000100;
  localparam opcode_t OP_J     = 6'b000010;

  localparam funct_t FN_ADD = 6'b100000;
  localparam funct_t FN_SUB = 6'b100010;
  localparam funct_t FN_AND = 6'b100100;
  localparam funct_t FN_OR  = 6'b100101;
  localparam funct_t FN_SLT = 6'b101010;

  localparam alu_op_t ALU_ADD = 3'b010;
  localparam alu_op_t ALU_SUB = 3'b110;
  localparam alu_op_t ALU_AND = 3'b000;
  localparam alu_op_t ALU_OR  = 3'b001;
  localparam alu_op_t ALU_SLT = 3'b111;

  localparam logic       SRC_A_PC      = 1'b0;
  localparam logic       SRC_A_REG     = 1'b1;
  localparam logic [1:0] SRC_B_REG     = 2'b00;
  localparam logic [1:0] SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] SRC_B_IMM     = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH  = 2'b11;
  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  // True for any opcode the controller has a sequence for.
  function automatic logic opcode_known(input opcode_t op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_ADDI) || (op == OP_BEQ) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mc_alu_decode.sv
// R-type funct to ALU operation decode; also flags unsupported funct codes.
module mc_alu_decode
  import mc_control_pkg::*;
(
  input  logic [FUNCT_W-1:0] funct,
  output logic [ALU_W-1:0]   alu_mod_c,
  output logic               funct_valid_c
);

  always_comb begin
    alu_mod_c     = ALU_ADD;
    funct_valid_c = 1'b1;
    case (funct)
      FN_ADD:  alu_mod_c = ALU_ADD;
      FN_SUB:  alu_mod_c = ALU_SUB;
      FN_AND:  alu_mod_c = ALU_AND;
      FN_OR:   alu_mod_c = ALU_OR;
      FN_SLT:  alu_mod_c = ALU_SLT;
      default: funct_valid_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle controller: sequences fetch/decode/execute/memory/writeback,
// drives ALU and mux controls, and counts retired instructions.
module mc_control
  import mc_control_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic                zero,
  input  logic                mem_ready,
  output logic [ALU_W-1:0]    alu_mod,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          pc_source,
  output logic                pc_en,
  output logic                iord,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                instr_done,
  output logic                illegal,
  output logic [CNT_W-1:0]    instr_count,
  output logic [STATE_W-1:0]  state
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   instr_count_q, instr_count_d;
  logic [ALU_W-1:0]   r_alu_mod;
  logic               funct_valid;
  logic               instr_legal;
  logic               pc_write;
  logic               pc_write_cond;

  mc_alu_decode u_alu_decode (
    .funct         (funct),
    .alu_mod_c     (r_alu_mod),
    .funct_valid_c (funct_valid)
  );

  assign instr_legal = opcode_known(opcode) && ((opcode != OP_RTYPE) || funct_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      instr_count_q <= instr_count_d;
    end
  end

  // Next state; memory states hold until the handshake completes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = FETCH;
      FETCH:     if (mem_ready) state_d = DECODE;
      DECODE: begin
        state_d = FETCH;
        if (instr_legal) begin
          case (opcode)
            OP_RTYPE:     state_d = R_EXEC;
            OP_LW, OP_SW: state_d = MEM_ADR;
            OP_ADDI:      state_d = ADDI_EXEC;
            OP_BEQ:       state_d = BRANCH;
            OP_J:         state_d = JUMP;
            default:      state_d = FETCH;
          endcase
        end
      end
      MEM_ADR:   state_d = (opcode == OP_LW) ? MEM_RD : MEM_WR;
      MEM_RD:    if (mem_ready) state_d = MEM_WB;
      MEM_WR:    if (mem_ready) state_d = FETCH;
      R_EXEC:    state_d = R_WB;
      ADDI_EXEC: state_d = ADDI_WB;
      MEM_WB, R_WB, ADDI_WB, BRANCH, JUMP: state_d = FETCH;
      default:   state_d = IDLE;
    endcase
  end

  // Moore decode of datapath controls; only ir_write, pc_en and store
  // completion look at mem_ready/zero.
  always_comb begin
    alu_mod       = ALU_ADD;
    alu_src_a     = SRC_A_PC;
    alu_src_b     = SRC_B_REG;
    pc_source     = PC_SRC_ALU;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    instr_done    = 1'b0;
    illegal       = 1'b0;
    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRC_B_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      DECODE: begin
        alu_src_b = SRC_B_IMM_SH;
        illegal   = !instr_legal;
      end
      MEM_ADR, ADDI_EXEC: begin
        alu_src_a = SRC_A_REG;
        alu_src_b = SRC_B_IMM;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      MEM_WB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      MEM_WR: begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
      end
      R_EXEC: begin
        alu_src_a = SRC_A_REG;
        alu_mod   = r_alu_mod;
      end
      R_WB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      ADDI_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = SRC_A_REG;
        alu_mod       = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PC_SRC_ALUOUT;
        instr_done    = 1'b1;
      end
      JUMP: begin
        pc_write   = 1'b1;
        pc_source  = PC_SRC_JUMP;
        instr_done = 1'b1;
      end
      default: ;
    endcase
    pc_en = pc_write | (pc_write_cond & zero);
  end

  always_comb begin
    instr_count_d = instr_count_q + CNT_W'(instr_done);
  end

  assign instr_count = instr_count_q;
  assign state       = state_q;

endmodule
